// File: rtl/mbe_pkg.sv
// Shared Booth select codes, digit count and encoder state encoding.
// MBE_ENC_UNSIGNED_EN selects an unsigned multiplier (one extra digit).
package mbe_pkg;

  // S[0] = zero, S[1] = 1x (else 2x), S[2] = take neg
  localparam logic [2:0] MBE_S_ZERO = 3'b001;
  localparam logic [2:0] MBE_S_P1   = 3'b010;
  localparam logic [2:0] MBE_S_P2   = 3'b000;
  localparam logic [2:0] MBE_S_M1   = 3'b110;
  localparam logic [2:0] MBE_S_M2   = 3'b100;

`ifdef MBE_ENC_UNSIGNED_EN
  localparam int MBE_N    = 5;
  localparam int MBE_SR_W = 10;
`else
  localparam int MBE_N    = 4;
  localparam int MBE_SR_W = 9;
`endif

  localparam logic [2:0] MBE_LAST_IDX = 3'(MBE_N - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } mbe_state_e;

endpackage

// File: rtl/mbe_enc_digit.sv
// Combinational radix-4 Booth triplet (b[2i+1], b[2i], b[2i-1]) to select code.
module mbe_enc_digit
  import mbe_pkg::*;
(
  input  logic [2:0] triplet,
  output logic [2:0] sel
);

  always_comb begin
    sel = MBE_S_ZERO;
    case (triplet)
      3'b001, 3'b010: sel = MBE_S_P1;
      3'b011:         sel = MBE_S_P2;
      3'b100:         sel = MBE_S_M2;
      3'b101, 3'b110: sel = MBE_S_M1;
      default:        sel = MBE_S_ZERO;
    endcase
  end

endmodule

// File: rtl/mbe_enc_seq.sv
// Sequential radix-4 modified-Booth encoder: one operand pair in, one digit per cycle out.
// Build option: MBE_ENC_UNSIGNED_EN (unsigned multiplier, five digits).
module mbe_enc_seq
  import mbe_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_mcand,
  input  logic [7:0] in_mplier,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] pos,
  output logic [7:0] neg,
  output logic [2:0] S,
  output logic [2:0] idx,
  output logic       last
);

  mbe_state_e          state;
  logic [MBE_SR_W-1:0] sr;
  logic [MBE_SR_W-1:0] sr_load;
  logic [MBE_SR_W-1:0] sr_shift;
  logic                accept;
  logic                xfer;

`ifdef MBE_ENC_UNSIGNED_EN
  assign sr_load  = {1'b0, in_mplier, 1'b0};
  assign sr_shift = {2'b00, sr[MBE_SR_W-1:2]};
`else
  assign sr_load  = {in_mplier, 1'b0};
  assign sr_shift = {{2{sr[MBE_SR_W-1]}}, sr[MBE_SR_W-1:2]};
`endif

  // The last-digit transfer frees the slot, so a new pair can load with no bubble
  assign out_valid = (state == ST_EMIT);
  assign last      = out_valid && (idx == MBE_LAST_IDX);
  assign in_ready  = (state == ST_IDLE) || (last && out_ready);
  assign accept    = in_valid && in_ready;
  assign xfer      = out_valid && out_ready;

  mbe_enc_digit u_digit (
    .triplet (sr[2:0]),
    .sel     (S)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      sr    <= '0;
      pos   <= '0;
      neg   <= '0;
      idx   <= '0;
    end else if (accept) begin
      state <= ST_EMIT;
      sr    <= sr_load;
      pos   <= in_mcand;
      neg   <= ~in_mcand + 8'd1;
      idx   <= '0;
    end else if (xfer) begin
      sr  <= sr_shift;
      idx <= idx + 3'd1;
      if (last) state <= ST_IDLE;
    end
  end

endmodule
